// File: rtl/stdp_update_sched.sv
// STDP weight-update sequencer: per-input spike timers, LTP/LTD request capture,
// and a one-weight-per-cycle saturating update engine over the weight bank.
module stdp_update_sched #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int WW      = 4,
    parameter int LTP_WIN = 8,
    parameter int LTD_WIN = 8,
    parameter int W_INIT  = 8,
    localparam int IW     = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_PRE-1:0]    pre_spike,
    input  logic                  post_spike,
    output logic [NUM_PRE*WW-1:0] weight,
    output logic                  busy,
    output logic                  upd_valid,
    output logic [IW-1:0]         upd_idx,
    output logic                  upd_dir,
    output logic                  ovf
);

    localparam logic [TW-1:0] T_MAX   = '1;
    localparam logic [WW-1:0] W_MAX   = '1;
    localparam logic [WW-1:0] W_RST   = WW'(W_INIT);
    localparam logic [TW:0]   LTP_LIM = (TW+1)'(LTP_WIN);
    localparam logic [TW:0]   LTD_LIM = (TW+1)'(LTD_WIN);
    localparam logic [IW-1:0] LAST    = IW'(NUM_PRE - 1);

    typedef enum logic [1:0] {IDLE, LTP_SCAN, LTD} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        pre_timer [NUM_PRE];
    logic [TW-1:0]        post_timer;
    logic [WW-1:0]        w [NUM_PRE];
    logic [NUM_PRE-1:0]   scan_mask, scan_n;
    logic [NUM_PRE-1:0]   pend_ltd, pend_n;
    logic [NUM_PRE-1:0]   post_pend_m, pp_m_n;
    logic                 post_pend_v, pp_v_n;
    logic                 ovf_n;
    logic [IW-1:0]        idx, idx_n;

    logic [NUM_PRE-1:0]   elig, ltd_set, ltd_clr;
    logic                 ltp_req, post_recent, ltd_found;
    logic [IW-1:0]        ltd_j, tgt;
    logic                 do_upd, dir;
    logic [WW-1:0]        w_cur, w_res;

    assign busy        = (state != IDLE);
    assign ltp_req     = en & post_spike;
    assign post_recent = ({1'b0, post_timer} < LTD_LIM);

    always_comb begin
        elig      = '0;
        ltd_set   = '0;
        ltd_j     = '0;
        ltd_found = 1'b0;
        for (int unsigned i = 0; i < NUM_PRE; i++) begin
            elig[i]    = pre_spike[i] | ({1'b0, pre_timer[i]} < LTP_LIM);
            ltd_set[i] = en & pre_spike[i] & ~post_spike & post_recent;
            if (pend_ltd[i] && !ltd_found) begin
                ltd_j     = IW'(i);
                ltd_found = 1'b1;
            end
        end
        ltd_clr = NUM_PRE'(1) << ltd_j;
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        scan_n  = scan_mask;
        pend_n  = pend_ltd | ltd_set;
        pp_v_n  = post_pend_v;
        pp_m_n  = post_pend_m;
        ovf_n   = ovf;
        do_upd  = 1'b0;
        tgt     = idx;
        dir     = 1'b1;

        // A post spike arriving while busy is parked in the one-deep slot.
        if (state != IDLE && ltp_req) begin
            if (post_pend_v) begin
                pp_m_n = post_pend_m | elig;
                ovf_n  = 1'b1;
            end else begin
                pp_m_n = elig;
                pp_v_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (ltp_req || post_pend_v) begin
                    scan_n  = (ltp_req ? elig : '0) | (post_pend_v ? post_pend_m : '0);
                    idx_n   = '0;
                    pp_v_n  = 1'b0;
                    pp_m_n  = '0;
                    state_n = LTP_SCAN;
                end else if (pend_ltd != '0) begin
                    state_n = LTD;
                end
            end
            LTP_SCAN: begin
                do_upd = scan_mask[idx];
                tgt    = idx;
                dir    = 1'b1;
                if (idx == LAST) state_n = IDLE;
                else             idx_n   = idx + 1'b1;
            end
            LTD: begin
                do_upd = ltd_found;
                tgt    = ltd_j;
                dir    = 1'b0;
                // Re-OR the new requests so a bit raised during its own service survives.
                pend_n = (pend_ltd & ~ltd_clr) | ltd_set;
                if (ltp_req || post_pend_v) state_n = IDLE;
                else if (pend_n != '0)      state_n = LTD;
                else                        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign w_cur = w[tgt];
    assign w_res = dir ? ((w_cur == W_MAX) ? w_cur : w_cur + 1'b1)
                       : ((w_cur == '0)    ? w_cur : w_cur - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            scan_mask   <= '0;
            pend_ltd    <= '0;
            post_pend_v <= 1'b0;
            post_pend_m <= '0;
            ovf         <= 1'b0;
            upd_valid   <= 1'b0;
            upd_idx     <= '0;
            upd_dir     <= 1'b0;
            for (int unsigned i = 0; i < NUM_PRE; i++) w[i] <= W_RST;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            scan_mask   <= scan_n;
            pend_ltd    <= pend_n;
            post_pend_v <= pp_v_n;
            post_pend_m <= pp_m_n;
            ovf         <= ovf_n;
            upd_valid   <= do_upd;
            if (do_upd) begin
                w[tgt]  <= w_res;
                upd_idx <= tgt;
                upd_dir <= dir;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_timer <= T_MAX;
            for (int unsigned i = 0; i < NUM_PRE; i++) pre_timer[i] <= T_MAX;
        end else begin
            if (post_spike)               post_timer <= '0;
            else if (post_timer != T_MAX) post_timer <= post_timer + 1'b1;
            for (int unsigned i = 0; i < NUM_PRE; i++) begin
                if (pre_spike[i])               pre_timer[i] <= '0;
                else if (pre_timer[i] != T_MAX) pre_timer[i] <= pre_timer[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PRE; g++) begin : g_flat
        assign weight[(NUM_PRE-1-g)*WW +: WW] = w[g];
    end

endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed bench for stdp_update_sched: per-cycle vector table plus hand-written
// saturation, post_pend overflow and mid-scan reset sequences.
module tb_stdp_update_sched;

    logic        clk = 1'b0;
    logic        rst_n, en, post_spike;
    logic [3:0]  pre_spike;
    logic [15:0] weight;
    logic        busy, upd_valid, upd_dir, ovf;
    logic [1:0]  upd_idx;

    always #5 clk = ~clk;

    stdp_update_sched #(
        .NUM_PRE(4), .TW(4), .WW(4), .LTP_WIN(8), .LTD_WIN(8), .W_INIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike),
        .post_spike(post_spike), .weight(weight), .busy(busy),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_dir(upd_dir), .ovf(ovf)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  pre;
        logic        post;
        logic [15:0] w;
        logic        busy;
        logic        uv;
        logic [1:0]  idx;
        logic        dir;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic e, input logic [3:0] p, input logic po,
                       input logic [15:0] w, input logic b, input logic u,
                       input logic [1:0] ix, input logic d, input logic o);
        vec_t v;
        v.rst_n = r; v.en = e; v.pre = p; v.post = po; v.w = w;
        v.busy = b; v.uv = u; v.idx = ix; v.dir = d; v.ovf = o;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic [15:0] w, input logic b);
        for (int i = 0; i < n; i++) add(1, 1, 4'b0000, 0, w, b, 0, 0, 0, 0);
    endtask

    task automatic rst_row();
        add(0, 1, 4'b0000, 0, 16'h8888, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] p, input logic po);
        @(negedge clk);
        rst_n = r; en = e; pre_spike = p; post_spike = po;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  w0_exp;
    logic [15:0] w_exp;
    int          pulses;

    initial begin
        rst_n = 0; en = 1; pre_spike = '0; post_spike = 0;

        // reset, then 20 quiet cycles
        rst_row(); rst_row();
        idle(20, 16'h8888, 0);
        // pre on idx0, post 3 cycles later -> LTP idx0
        add(1, 1, 4'b0001, 0, 16'h8888, 0, 0, 0, 0, 0);
        idle(2, 16'h8888, 0);
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h9888, 1, 1, 0, 1, 0);
        idle(2, 16'h9888, 1);
        idle(2, 16'h9888, 0);
        // post then pre 0110 two cycles later -> LTD idx1, idx2
        rst_row();
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0110, 0, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8888, 0, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8788, 1, 1, 1, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h8778, 0, 1, 2, 0, 0);
        idle(1, 16'h8778, 0);
        // simultaneous pre/post on idx3 -> LTP idx3
        rst_row();
        add(1, 1, 4'b1000, 1, 16'h8888, 1, 0, 0, 0, 0);
        idle(3, 16'h8888, 1);
        add(1, 1, 4'b0000, 0, 16'h8889, 0, 1, 3, 1, 0);
        idle(1, 16'h8889, 0);
        // pre 10 cycles before post -> outside window, no update
        rst_row();
        add(1, 1, 4'b0001, 0, 16'h8888, 0, 0, 0, 0, 0);
        idle(9, 16'h8888, 0);
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        idle(3, 16'h8888, 1);
        idle(1, 16'h8888, 0);
        // pre 8 cycles before post -> timer 7, last eligible value
        rst_row();
        add(1, 1, 4'b0010, 0, 16'h8888, 0, 0, 0, 0, 0);
        idle(7, 16'h8888, 0);
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        idle(1, 16'h8888, 1);
        add(1, 1, 4'b0000, 0, 16'h8988, 1, 1, 1, 1, 0);
        idle(1, 16'h8988, 1);
        idle(1, 16'h8988, 0);
        // en=0 blocks capture but timers keep running
        rst_row();
        add(1, 0, 4'b0001, 1, 16'h8888, 0, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 0, 16'h8888, 0, 0, 0, 0, 0);
        add(1, 0, 4'b0010, 0, 16'h8888, 0, 0, 0, 0, 0);
        idle(2, 16'h8888, 0);
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h9888, 1, 1, 0, 1, 0);
        add(1, 1, 4'b0000, 0, 16'h9988, 1, 1, 1, 1, 0);
        idle(1, 16'h9988, 1);
        idle(1, 16'h9988, 0);
        // LTD bit re-raised while being serviced is serviced again
        rst_row();
        add(1, 1, 4'b0000, 1, 16'h8888, 1, 0, 0, 0, 0);
        add(1, 1, 4'b0011, 0, 16'h8888, 1, 0, 0, 0, 0);
        idle(2, 16'h8888, 1);
        idle(1, 16'h8888, 0);
        idle(1, 16'h8888, 1);
        add(1, 1, 4'b0001, 0, 16'h7888, 1, 1, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h6888, 1, 1, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 16'h6788, 0, 1, 1, 0, 0);
        idle(1, 16'h6788, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst_n, tbl[i].en, tbl[i].pre, tbl[i].post);
            chk($sformatf("v%0d weight", i), weight, tbl[i].w);
            chk($sformatf("v%0d busy", i), 16'(busy), 16'(tbl[i].busy));
            chk($sformatf("v%0d upd_valid", i), 16'(upd_valid), 16'(tbl[i].uv));
            chk($sformatf("v%0d ovf", i), 16'(ovf), 16'(tbl[i].ovf));
            if (tbl[i].uv) begin
                chk($sformatf("v%0d upd_idx", i), 16'(upd_idx), 16'(tbl[i].idx));
                chk($sformatf("v%0d upd_dir", i), 16'(upd_dir), 16'(tbl[i].dir));
            end
        end

        // LTP saturation on idx0: ten coincident spikes, 6 cycles apart
        cyc(0, 1, 4'b0000, 0);
        w0_exp = 4'h8;
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 1, 4'b0001, 1);
            chk($sformatf("sat%0d busy", k), 16'(busy), 16'd1);
            cyc(1, 1, 4'b0000, 0);
            w0_exp = (w0_exp == 4'hF) ? 4'hF : w0_exp + 4'h1;
            chk($sformatf("sat%0d upd_valid", k), 16'(upd_valid), 16'd1);
            chk($sformatf("sat%0d upd_idx", k), 16'(upd_idx), 16'd0);
            chk($sformatf("sat%0d upd_dir", k), 16'(upd_dir), 16'd1);
            chk($sformatf("sat%0d weight", k), weight, {w0_exp, 12'h888});
            for (int j = 0; j < 4; j++) cyc(1, 1, 4'b0000, 0);
            chk($sformatf("sat%0d idle", k), 16'(busy), 16'd0);
        end

        // three consecutive post spikes: one queued, one merged with ovf
        cyc(0, 1, 4'b0000, 0);
        pulses = 0;
        for (int p = 0; p < 20; p++) begin
            if (p == 0)           cyc(1, 1, 4'b0001, 1);
            else if (p <= 2)      cyc(1, 1, 4'b0000, 1);
            else                  cyc(1, 1, 4'b0000, 0);
            if (upd_valid) pulses++;
            w_exp = (p >= 6) ? 16'hA888 : (p >= 1) ? 16'h9888 : 16'h8888;
            chk($sformatf("ovf p%0d upd_valid", p), 16'(upd_valid), 16'((p == 1) || (p == 6)));
            chk($sformatf("ovf p%0d busy", p), 16'(busy), 16'((p <= 3) || (p >= 5 && p <= 8)));
            chk($sformatf("ovf p%0d ovf", p), 16'(ovf), 16'(p >= 2));
            chk($sformatf("ovf p%0d weight", p), weight, w_exp);
        end
        chk("ovf pulse count", 16'(pulses), 16'd2);

        // reset in the middle of a full-mask scan
        cyc(1, 1, 4'b1111, 1);
        cyc(1, 1, 4'b0000, 0);
        chk("mid q1 weight", weight, 16'hB888);
        cyc(1, 1, 4'b0000, 0);
        chk("mid q2 weight", weight, 16'hB988);
        cyc(0, 1, 4'b0000, 0);
        chk("mid rst weight", weight, 16'h8888);
        chk("mid rst ovf", 16'(ovf), 16'd0);
        chk("mid rst busy", 16'(busy), 16'd0);
        chk("mid rst upd_valid", 16'(upd_valid), 16'd0);
        for (int j = 0; j < 6; j++) begin
            cyc(1, 1, 4'b0000, 0);
            chk($sformatf("post-rst%0d upd_valid", j), 16'(upd_valid), 16'd0);
            chk($sformatf("post-rst%0d busy", j), 16'(busy), 16'd0);
            chk($sformatf("post-rst%0d weight", j), weight, 16'h8888);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
